// File: rtl/ram_bridge_pkg.sv
// Shared types for the two-cycle RAM bridge: response entry layout and access size codes.
package ram_bridge_pkg;

  localparam int RESP_DATA_W = 32;

  typedef struct packed {
    logic                   we;
    logic [RESP_DATA_W-1:0] data;
  } resp_ent_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/ram_2cyc_bridge_resp_fifo.sv
// Synchronous in-order FIFO with occupancy count; head is read straight from storage flops.
// Zero-latency pop, push visible one cycle later; caller must never push when full or pop when empty.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_en,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_en,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  assert property (@(posedge clk) disable iff (!rst_n) !(push_en && count_q == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop_en && count_q == '0));

endmodule

// File: rtl/ram_2cyc_bridge.sv
// Valid/ready front-end for the two-cycle RAM: strobes issued on accept, results queued in a response FIFO.
// Accept-to-resp_valid is 2 cycles; req_ready is a registered credit check so response stalls never drop data.
module ram_2cyc_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_we,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    ram_en,
  output logic                    ram_re,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [1:0]              ram_size,
  output logic [DATA_WIDTH/8-1:0] ram_wmask,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic                inflight_vld_q, inflight_vld_d;
  logic                inflight_we_q, inflight_we_d;
  logic                accept;
  logic                pop;
  logic [CW-1:0]       fifo_count;
  logic [DATA_WIDTH:0] push_dat;
  logic [DATA_WIDTH:0] head_dat;

  // The in-flight slot reserves its FIFO entry up front, so the push a cycle later always fits.
  assign req_ready = rst && ((fifo_count + CW'(inflight_vld_q)) < CW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  assign ram_en    = accept;
  assign ram_we    = accept && req_we;
  assign ram_re    = accept && !req_we;
  assign ram_addr  = req_addr;
  assign ram_size  = req_size;
  assign ram_wmask = req_wmask;
  assign ram_wdata = req_wdata;

  always_comb begin
    inflight_vld_d = accept;
    inflight_we_d  = req_we;
    push_dat       = {inflight_we_q, inflight_we_q ? {DATA_WIDTH{1'b0}} : ram_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_vld_q <= 1'b0;
      inflight_we_q  <= 1'b0;
    end else begin
      inflight_vld_q <= inflight_vld_d;
      inflight_we_q  <= inflight_we_d;
    end
  end

  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;

  resp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push_en  (inflight_vld_q),
    .push_dat (push_dat),
    .pop_en   (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign resp_we    = head_dat[DATA_WIDTH];
  assign resp_rdata = head_dat[DATA_WIDTH-1:0];

  assert property (@(posedge clk) disable iff (!rst) accept |-> size_bytes(req_size) <= DATA_WIDTH / 8);

endmodule

// File: tb/tb_ram_2cyc_bridge.sv
// Bench for ram_2cyc_bridge: directed vector table, corner sequences and a queue-based reference model.
module tb_ram_2cyc_bridge;
  import ram_bridge_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic [3:0]    req_wmask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_we;
  logic [DW-1:0] resp_rdata;
  logic          ram_en, ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_size;
  logic [3:0]    ram_wmask;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram_2cyc_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we), .resp_rdata(resp_rdata),
    .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_size(ram_size), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM the bridge talks to: registered read, byte-masked write.
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en && ram_re) ram_rdata <= ram_mem[ram_addr[9:2]];
    if (ram_en && ram_we) ram_mem[ram_addr[9:2]] <= merge(ram_mem[ram_addr[9:2]], ram_wdata, ram_wmask);
  end

  // Reference model: expected response queue, one pending slot, shadow memory.
  resp_ent_t   exp_q[$];
  bit          pend_v;
  resp_ent_t   pend_e;
  logic [31:0] shadow [256];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int dut_acc   = 0;
  int pop_log[$];

  typedef struct {
    logic        v, we;
    logic [31:0] addr, wdata;
    logic        rr;
    logic        e_en, e_re, e_we, e_rdy, e_rv, e_rwe;
    logic [31:0] e_rd;
  } vec_t;

  bit   tbl_en;
  vec_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cycle(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic rr);
    bit exp_rdy, acc, pop;
    int idx;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wmask = m;
    req_size = SIZE_W; resp_ready = rr;
    @(negedge clk);
    exp_rdy = (exp_q.size() + int'(pend_v)) < DEPTH;
    acc     = v && exp_rdy;
    pop     = (exp_q.size() != 0) && rr;
    check("req_ready", req_ready, exp_rdy);
    check("ram_en", ram_en, acc);
    check("ram_we", ram_we, acc && we);
    check("ram_re", ram_re, acc && !we);
    if (acc) begin
      check("ram_addr", ram_addr, a);
      check("ram_size", ram_size, SIZE_W);
      if (we) begin
        check("ram_wdata", ram_wdata, wd);
        check("ram_wmask", ram_wmask, m);
      end
    end
    check("resp_valid", resp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("resp_we", resp_we, exp_q[0].we);
      check("resp_rdata", resp_rdata, exp_q[0].data);
    end
    if (tbl_en) begin
      check("tbl_ram_en", ram_en, cur.e_en);
      check("tbl_ram_re", ram_re, cur.e_re);
      check("tbl_ram_we", ram_we, cur.e_we);
      check("tbl_req_ready", req_ready, cur.e_rdy);
      check("tbl_resp_valid", resp_valid, cur.e_rv);
      if (cur.e_rv) begin
        check("tbl_resp_we", resp_we, cur.e_rwe);
        check("tbl_resp_rdata", resp_rdata, cur.e_rd);
      end
    end
    if (ram_en) dut_acc++;
    if (resp_valid && resp_ready) pop_log.push_back(cyc);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (pend_v) exp_q.push_back(pend_e);
    pend_v = acc;
    if (acc) begin
      idx       = int'(a[9:2]);
      pend_e.we = we;
      pend_e.data = we ? 32'h0 : shadow[idx];
      if (we) shadow[idx] = merge(shadow[idx], wd, m);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr);
  endtask

  vec_t tbl [5];
  int   start;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      shadow[i]  = ram_mem[i];
    end
    ram_rdata = '0;
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0000;
    req_size = SIZE_W; req_wmask = 4'hF; req_wdata = '0; resp_ready = 1'b1;
    pend_v = 1'b0; pend_e = '0; tbl_en = 1'b0;

    // Reset held for 3 cycles with a request offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_ram_en", ram_en, 1'b0);
      check("rst_ram_re", ram_re, 1'b0);
      check("rst_ram_we", ram_we, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_resp_valid", resp_valid, 1'b0);
    check("post_rst_resp_we", resp_we, 1'b0);
    check("post_rst_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;

    // Write then read the same word, consumer always ready.
    tbl[0] = '{1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cur = tbl[i];
      cycle(cur.v, cur.we, cur.addr, cur.wdata, 4'hF, cur.rr);
    end
    tbl_en = 1'b0;

    // Eight back-to-back reads: responses on 8 consecutive cycles, 2 after the first accept.
    pop_log.delete();
    start = cyc;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h8000_0000 | (i << 2), 32'h0, 4'h0, 1'b1);
    idle(3, 1'b1);
    check("b2b_resp_count", pop_log.size(), 8);
    if (pop_log.size() == 8) begin
      check("b2b_first_resp", pop_log[0] - start, 2);
      check("b2b_last_resp", pop_log[7] - start, 9);
    end

    // Consumer stalled: exactly DEPTH accepts, then drain in order.
    dut_acc = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h8000_0040 | (i << 2), 32'h0, 4'h0, 1'b0);
    check("stall_accepts", dut_acc, 4);
    pop_log.delete();
    idle(6, 1'b1);
    check("stall_drain_count", pop_log.size(), 4);

    // Simultaneous push and pop while holding 3 entries.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h8000_0080 | (i << 2), 32'h0, 4'h0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 1'b0, 32'h8000_008C, 32'h0, 4'h0, 1'b0);
    idle(1, 1'b1);
    cycle(1'b1, 1'b0, 32'h8000_0090, 32'h0, 4'h0, 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Reset one cycle after a read accept: the in-flight read must vanish.
    cycle(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b1);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); pend_v = 1'b0;
    pop_log.delete();
    idle(4, 1'b1);
    check("midrst_no_resp", pop_log.size(), 0);
    dut_acc = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h8000_0000 | (i << 2), 32'h0, 4'h0, 1'b0);
    check("midrst_accepts", dut_acc, 4);
    idle(6, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            32'h8000_0000 | ($urandom_range(0, 15) << 2), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    idle(8, 1'b1);
    check("final_drained", resp_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
